// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with clear, clamped load, enable, wrap/saturate mode and tc/wrap flags.
// Define CNT_PRESCALE_EN to qualify the count enable with a PRESCALE-cycle prescaler.
module mod_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 9,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cntQ, cntD;
  logic             wrapQ, wrapD;
  logic             stepEn;

`ifdef CNT_PRESCALE_EN
  localparam int unsigned PscW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PscW-1:0] PscLast = PscW'(PRESCALE - 1);

  logic [PscW-1:0] pscQ, pscD;

  // Only the en cycle that completes a prescale period becomes a counting step.
  assign stepEn = en && (pscQ == PscLast);

  always_comb begin
    pscD = pscQ;
    if (clr || load) begin
      pscD = '0;
    end else if (en) begin
      if (pscQ == PscLast) begin
        pscD = '0;
      end else begin
        pscD = pscQ + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pscQ <= '0;
    end else begin
      pscQ <= pscD;
    end
  end
`else
  assign stepEn = en;
`endif

  // Values above MaxVal can only come from a glitch; they are steered back into range.
  always_comb begin
    cntD  = cntQ;
    wrapD = 1'b0;
    if (clr) begin
      cntD = '0;
    end else if (load) begin
      cntD = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (stepEn) begin
      if (up) begin
        if (cntQ < MaxVal) begin
          cntD = cntQ + 1'b1;
        end else if (cntQ > MaxVal) begin
          cntD  = '0;
          wrapD = 1'b1;
        end else if (!sat) begin
          cntD  = '0;
          wrapD = 1'b1;
        end
      end else begin
        if (cntQ > MaxVal) begin
          cntD = MaxVal;
        end else if (cntQ != '0) begin
          cntD = cntQ - 1'b1;
        end else if (!sat) begin
          cntD  = MaxVal;
          wrapD = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntQ  <= '0;
      wrapQ <= 1'b0;
    end else begin
      cntQ  <= cntD;
      wrapQ <= wrapD;
    end
  end

  assign cnt  = cntQ;
  assign wrap = wrapQ;
  assign tc   = up ? (cntQ == MaxVal) : (cntQ == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter (WIDTH=4, MAX_VAL=9, PRESCALE=4).
// The prescaler scenario runs only when CNT_PRESCALE_EN is defined.
module tb_mod_updown_counter;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up;
  logic       sat;
  logic [3:0] cnt;
  logic       tc;
  logic       wrap;

  int testsRun    = 0;
  int testsFailed = 0;

  mod_updown_counter #(
    .WIDTH   (4),
    .MAX_VAL (9),
    .PRESCALE(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .up      (up),
    .sat     (sat),
    .cnt     (cnt),
    .tc      (tc),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic clrV, input logic loadV, input logic [3:0] loadValV,
                               input logic enV, input logic upV, input logic satV);
    clr      = clrV;
    load     = loadV;
    load_val = loadValV;
    en       = enV;
    up       = upV;
    sat      = satV;
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input int expCnt, input int expWrap, input int expTc);
    checkOutput({tag, ".cnt"}, 32'(cnt), 32'(expCnt));
    checkOutput({tag, ".wrap"}, 32'(wrap), 32'(expWrap));
    checkOutput({tag, ".tc"}, 32'(tc), 32'(expTc));
  endtask

  initial begin
    int downCnt[5];
    int downWrap[5];
    downCnt  = '{2, 1, 0, 9, 8};
    downWrap = '{0, 0, 0, 1, 0};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    repeat (2) nextEdge();
    checkState("reset", 0, 0, 0);
    rst = 1'b0;

    // Up count with wrap: 1..9, then 0 with a wrap pulse, then 1.
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      nextEdge();
      checkState($sformatf("up%0d", i), i % 10, (i == 10) ? 1 : 0, (i % 10 == 9) ? 1 : 0);
    end

    // Load 3 then count down through the 0 -> 9 wrap.
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    nextEdge();
    checkState("load3", 3, 0, 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      nextEdge();
      checkState($sformatf("down%0d", i), downCnt[i], downWrap[i], (downCnt[i] == 0) ? 1 : 0);
    end

    // Saturating up from 8 and saturating down from 1.
    applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 1'b1);
    nextEdge();
    checkState("load8", 8, 0, 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      nextEdge();
      checkState($sformatf("satUp%0d", i), 9, 0, 1);
    end
    applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    nextEdge();
    checkState("load1", 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      nextEdge();
      checkState($sformatf("satDown%0d", i), 0, 0, 1);
    end

    // Priority and clamping: clr beats load, out-of-range loads clamp to 9.
    applyStimulus(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
    nextEdge();
    checkState("clrWins", 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 1'b0);
    nextEdge();
    checkState("clamp15", 9, 0, 1);
    applyStimulus(1'b0, 1'b1, 4'd10, 1'b0, 1'b1, 1'b0);
    nextEdge();
    checkState("clamp10", 9, 0, 1);
    applyStimulus(1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
    nextEdge();
    checkState("loadBeatsStep", 4, 0, 0);
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
    nextEdge();
    checkState("load9", 9, 0, 1);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nextEdge();
      checkState($sformatf("hold%0d", i), 9, 0, 1);
    end

    // Asynchronous reset between edges at cnt=7, then first step after release.
    applyStimulus(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    nextEdge();
    checkState("load7", 7, 0, 0);
    #2 rst = 1'b1;
    #1 checkState("asyncRst7", 0, 0, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    nextEdge();
    checkState("afterRst", 1, 0, 0);

    // Asynchronous reset while a wrap pulse is showing.
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
    nextEdge();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    nextEdge();
    checkState("wrapBeforeRst", 0, 1, 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 checkOutput("asyncRstWrap", 32'(wrap), 32'd0);
    rst = 1'b0;
    nextEdge();

`ifdef CNT_PRESCALE_EN
    begin
      int pscM = 0;
      int cntM = 0;
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      nextEdge();
      checkState("pscClr", 0, 0, 0);
      for (int i = 1; i <= 14; i++) begin
        logic enV;
        enV = !(i == 6 || i == 7);
        applyStimulus(1'b0, 1'b0, 4'd0, enV, 1'b1, 1'b0);
        if (enV) begin
          if (pscM == 3) begin
            pscM = 0;
            cntM = (cntM + 1) % 10;
          end else begin
            pscM++;
          end
        end
        nextEdge();
        checkOutput($sformatf("psc%0d.cnt", i), 32'(cnt), 32'(cntM));
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
